// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell sequenced LSB first, one bit per clock.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN (adds the sub input).
module serial_add_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   // Mask selecting the result MSB, built without zero-width replications so WIDTH=1 is legal.
   localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(64'd1 << (WIDTH - 1));

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             c_q, c_d;
   logic             cout_q, cout_d;
   logic             cell_s, cell_co;
   logic             sub_eff;
   logic [WIDTH-1:0] r_shift;

`ifdef SERIAL_ADD_SUB_EN
   assign sub_eff = sub;
`else
   assign sub_eff = 1'b0;
`endif

   // The shared full-adder cell.
   assign cell_s  = a_q[0] ^ b_q[0] ^ c_q;
   assign cell_co = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

   assign r_shift = (r_q >> 1) | ({WIDTH{cell_s}} & MSB_MASK);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      cout_d  = cout_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = a;
               // Subtract as a + ~b + 1: invert B and force the carry-in.
               b_d     = sub_eff ? ~b : b;
               c_d     = sub_eff ? 1'b1 : cin;
               r_d     = '0;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            r_d   = r_shift;
            c_d   = cell_co;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               sum_d   = r_shift;
               cout_d  = cell_co;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         cout_q  <= cout_d;
      end
   end

   assign busy = (state_q == StRun);
   assign done = (state_q == StDone);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: latency/arithmetic model checked every cycle,
// plus directed operations with hand-computed results.
module tb_serial_add_ctrl;

   localparam int unsigned WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .a    (a),
      .b    (b),
      .cin  (cin),
`ifdef SERIAL_ADD_SUB_EN
      .sub  (sub),
`endif
      .busy (busy),
      .done (done),
      .sum  (sum),
      .cout (cout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: an accepted start yields WIDTH busy cycles, then one done cycle,
   // with the arithmetic result published when done rises.
   int               m_left = 0;
   bit               m_done = 1'b0;
   logic [WIDTH-1:0] m_sum = '0;
   logic             m_cout = 1'b0;
   logic [WIDTH-1:0] p_sum = '0;
   logic             p_cout = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_left <= 0;
         m_done <= 1'b0;
         m_sum  <= '0;
         m_cout <= 1'b0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_done <= 1'b1;
            m_sum  <= p_sum;
            m_cout <= p_cout;
         end
      end else if (start) begin
         m_left <= WIDTH;
`ifdef SERIAL_ADD_SUB_EN
         if (sub) begin
            p_sum  <= a - b;
            p_cout <= (a >= b);
         end else begin
            {p_cout, p_sum} <= {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(cin);
         end
`else
         {p_cout, p_sum} <= {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(cin);
`endif
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy", 32'(busy), 32'(m_left > 0));
         chk("done", 32'(done), 32'(m_done));
         chk("sum", 32'(sum), 32'(m_sum));
         chk("cout", 32'(cout), 32'(m_cout));
      end
   end

   task automatic run_op(input string name, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic icin, input logic isub, input bit noise,
                         input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
      int busy_n = 0;
      int done_n = 0;
      int done_at = -1;
      a     = ia;
      b     = ib;
      cin   = icin;
      sub   = isub;
      start = 1'b1;
      for (int i = 0; i < WIDTH + 4; i++) begin
         @(negedge clk);
         if (i == 0) start = 1'b0;
         if (noise && i >= 1 && i <= 4) begin
            start = 1'b1;
            a     = 8'h03;
            b     = 8'h04;
            cin   = 1'b1;
         end
         if (noise && i == 5) start = 1'b0;
         busy_n += int'(busy);
         done_n += int'(done);
         if (done && done_at < 0) done_at = i;
      end
      chk({name, " busy cycles"}, 32'(busy_n), WIDTH);
      chk({name, " done count"}, 32'(done_n), 32'd1);
      chk({name, " done latency"}, 32'(done_at), WIDTH);
      chk({name, " sum"}, 32'(sum), 32'(exp_sum));
      chk({name, " cout"}, 32'(cout), 32'(exp_cout));
   endtask

   initial begin
      int done_n;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      sub   = 1'b0;
      repeat (2) @(negedge clk);
      cmp_en = 1'b1;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset sum", 32'(sum), 32'h00);
      chk("reset cout", 32'(cout), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle busy", 32'(busy), 32'd0);

      run_op("ff+01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      repeat (2) @(negedge clk);
      chk("ff+01 held sum", 32'(sum), 32'h00);
      chk("ff+01 held cout", 32'(cout), 32'd1);

      run_op("5a+a5+1", 8'h5A, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      run_op("12+34", 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 8'h46, 1'b0);
      run_op("0f+01 noisy", 8'h0F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0);

      // Reset four bits into an operation: no done, outputs cleared.
      a     = 8'hAA;
      b     = 8'h55;
      cin   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      done_n = 0;
      for (int i = 0; i < WIDTH + 4; i++) begin
         @(negedge clk);
         done_n += int'(done);
      end
      chk("abort done count", 32'(done_n), 32'd0);
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort sum", 32'(sum), 32'h00);
      chk("abort cout", 32'(cout), 32'd0);

      // Reset and start on the same edge: start is lost.
      rst   = 1'b1;
      start = 1'b1;
      a     = 8'h01;
      b     = 8'h01;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("rst+start busy", 32'(busy), 32'd0);

      run_op("01+01", 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0);

      // Start held high restarts on every IDLE visit.
      a     = 8'h01;
      b     = 8'h02;
      cin   = 1'b0;
      start = 1'b1;
      done_n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         done_n += int'(done);
      end
      start = 1'b0;
      chk("held start done count", 32'(done_n), 32'd2);
      repeat (WIDTH + 4) @(negedge clk);
      chk("held start sum", 32'(sum), 32'h03);

`ifdef SERIAL_ADD_SUB_EN
      run_op("10-01", 8'h10, 8'h01, 1'b0, 1'b1, 1'b0, 8'h0F, 1'b1);
      run_op("00-01", 8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0);
      run_op("10-01 cin", 8'h10, 8'h01, 1'b1, 1'b1, 1'b0, 8'h0F, 1'b1);
      run_op("12+34 sub0", 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 8'h46, 1'b0);
`endif

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
